// File: rtl/can_regbank_pkg.sv
// Shared definitions for the CAN register bank: bit-mode flags, register
// extraction from a packed bank image and parameter sanity checks.
package can_regbank_pkg;

   // A bit whose mode has no flag set is a constant held at its reset value.
   localparam logic [2:0] MODE_WR = 3'b001;
   localparam logic [2:0] MODE_HW = 3'b010;
   localparam logic [2:0] MODE_RC = 3'b100;

   localparam int MAX_DEPTH = 16;
   localparam int MAX_WIDTH = 32;
   localparam int MAX_BITS  = MAX_DEPTH * MAX_WIDTH;

   function automatic logic [2:0] bit_mode(input logic wr, input logic hw, input logic rc);
      return {rc, hw, wr};
   endfunction

   function automatic logic [MAX_WIDTH-1:0] get_reg(input logic [MAX_BITS-1:0] vec,
                                                    input int idx, input int width);
      logic [MAX_BITS-1:0] shifted;
      shifted = vec >> (idx * width);
      return shifted[MAX_WIDTH-1:0];
   endfunction

   function automatic bit depth_ok(input int depth, input int addr_w);
      return (depth >= 1) && (depth <= MAX_DEPTH) && ((1 << addr_w) >= depth);
   endfunction

endpackage

// File: rtl/can_register_bank_if.sv
// CPU-side access port of the register bank: strobes, address, data and
// the registered read/error responses.
interface can_register_bank_if #(
   parameter int WIDTH  = 8,
   parameter int ADDR_W = 4
);
   logic              cs;
   logic              we;
   logic              re;
   logic [ADDR_W-1:0] addr;
   logic [WIDTH-1:0]  wdata;
   logic [WIDTH-1:0]  rdata;
   logic              rvalid;
   logic              err;

   modport master (output cs, we, re, addr, wdata, input rdata, rvalid, err);
   modport slave  (input cs, we, re, addr, wdata, output rdata, rvalid, err);
endinterface

// File: rtl/can_regbank_word.sv
// One register of the bank: per-bit mode masks and the priority mux
// hw_set > read-clear > CPU write.
module can_regbank_word
   import can_regbank_pkg::*;
#(
   parameter int               WIDTH       = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter logic [WIDTH-1:0] WR_MASK     = '1,
   parameter logic [WIDTH-1:0] HW_MASK     = '0,
   parameter logic [WIDTH-1:0] RC_MASK     = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic             rc_en,
   input  logic [WIDTH-1:0] wdata,
   input  logic [WIDTH-1:0] hw_set,
   output logic [WIDTH-1:0] value,
   output logic [WIDTH-1:0] next_value
);

   logic [WIDTH-1:0] value_q;
   logic [WIDTH-1:0] value_d;
   logic [2:0]       mode;

   // Later assignments win, so the lowest-priority source is applied first.
   always_comb begin
      value_d = value_q;
      mode    = '0;
      for (int b = 0; b < WIDTH; b++) begin
         mode = bit_mode(WR_MASK[b], HW_MASK[b], RC_MASK[b]);
         if (wr_en && ((mode & MODE_WR) != 3'b000))
            value_d[b] = wdata[b];
         if (rc_en && ((mode & MODE_RC) != 3'b000))
            value_d[b] = 1'b0;
         if (hw_set[b] && ((mode & MODE_HW) != 3'b000))
            value_d[b] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         value_q <= RESET_VALUE;
      else
         value_q <= value_d;
   end

   assign value      = value_q;
   assign next_value = value_d;

endmodule

// File: rtl/can_register_bank.sv
// Parametrised CSR bank for the CAN controller: address decode, lock check,
// registered read port and aggregated interrupt over the generated words.
module can_register_bank
   import can_regbank_pkg::*;
#(
   parameter int                     WIDTH       = 8,
   parameter int                     DEPTH       = 4,
   parameter int                     ADDR_W      = 4,
   parameter logic [DEPTH*WIDTH-1:0] RESET_VALUE = '0,
   parameter logic [DEPTH*WIDTH-1:0] WR_MASK     = '1,
   parameter logic [DEPTH*WIDTH-1:0] HW_MASK     = '0,
   parameter logic [DEPTH*WIDTH-1:0] RC_MASK     = '0,
   parameter logic [DEPTH-1:0]       LOCK_MASK   = '0
) (
   input  logic                   clk,
   input  logic                   rst,
   can_register_bank_if.slave     bus,
   input  logic                   lock,
   input  logic [DEPTH*WIDTH-1:0] hw_set,
   output logic                   irq,
   output logic [DEPTH*WIDTH-1:0] regs
);

   logic                   in_range;
   logic                   lock_hit;
   logic                   wr_ok;
   logic                   rd_acc;
   logic [DEPTH-1:0]       wr_sel;
   logic [DEPTH-1:0]       rc_sel;
   logic [DEPTH*WIDTH-1:0] regs_next;
   logic [WIDTH-1:0]       rd_word;

   logic [WIDTH-1:0] rdata_q, rdata_d;
   logic             rvalid_q, rvalid_d;
   logic             err_q, err_d;
   logic             irq_q, irq_d;

   // Lock only matters for in-range addresses; out-of-range is already an error.
   always_comb begin
      in_range = 32'(bus.addr) < DEPTH;
      lock_hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (bus.addr == ADDR_W'(i))
            lock_hit = lock & LOCK_MASK[i];
      end
      wr_ok  = bus.cs & bus.we & in_range & ~lock_hit;
      rd_acc = bus.cs & bus.re & ~bus.we;
   end

   for (genvar i = 0; i < DEPTH; i++) begin : g_word
      assign wr_sel[i] = wr_ok & (bus.addr == ADDR_W'(i));
      assign rc_sel[i] = rd_acc & in_range & (bus.addr == ADDR_W'(i));

      can_regbank_word #(
         .WIDTH       (WIDTH),
         .RESET_VALUE (RESET_VALUE[i*WIDTH +: WIDTH]),
         .WR_MASK     (WR_MASK[i*WIDTH +: WIDTH]),
         .HW_MASK     (HW_MASK[i*WIDTH +: WIDTH]),
         .RC_MASK     (RC_MASK[i*WIDTH +: WIDTH])
      ) u_word (
         .clk        (clk),
         .rst        (rst),
         .wr_en      (wr_sel[i]),
         .rc_en      (rc_sel[i]),
         .wdata      (bus.wdata),
         .hw_set     (hw_set[i*WIDTH +: WIDTH]),
         .value      (regs[i*WIDTH +: WIDTH]),
         .next_value (regs_next[i*WIDTH +: WIDTH])
      );
   end

   // Read data is the pre-clear value; irq tracks next-state so it lines up with regs.
   always_comb begin
      rd_word  = WIDTH'(get_reg(MAX_BITS'(regs), 32'(bus.addr), WIDTH));
      rdata_d  = rdata_q;
      rvalid_d = rd_acc;
      err_d    = (bus.cs & bus.we & (~in_range | lock_hit)) | (rd_acc & ~in_range);
      if (rd_acc)
         rdata_d = in_range ? rd_word : '0;
      irq_d = |(regs_next & HW_MASK);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
         irq_q    <= |(RESET_VALUE & HW_MASK);
      end else begin
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
         err_q    <= err_d;
         irq_q    <= irq_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst)
         assert (depth_ok(DEPTH, ADDR_W));
   end

   assign bus.rdata  = rdata_q;
   assign bus.rvalid = rvalid_q;
   assign bus.err    = err_q;
   assign irq        = irq_q;

endmodule

// File: tb/tb_can_register_bank.sv
// Self-checking bench for can_register_bank: directed scenarios followed by
// random traffic, all checked against an access-level reference model.
module tb_can_register_bank;

   localparam int WIDTH  = 8;
   localparam int DEPTH  = 3;
   localparam int ADDR_W = 4;
   localparam int NB     = DEPTH * WIDTH;

   localparam logic [NB-1:0]    P_RESET = 24'h00A500;
   localparam logic [NB-1:0]    P_WR    = 24'hF00FFF;
   localparam logic [NB-1:0]    P_HW    = 24'h010100;
   localparam logic [NB-1:0]    P_RC    = 24'h0F0000;
   localparam logic [DEPTH-1:0] P_LOCK  = 3'b001;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          lock = 1'b0;
   logic [NB-1:0] hw_set = '0;
   logic          irq;
   logic [NB-1:0] regs;

   can_register_bank_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

   can_register_bank #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
      .RESET_VALUE(P_RESET), .WR_MASK(P_WR), .HW_MASK(P_HW),
      .RC_MASK(P_RC), .LOCK_MASK(P_LOCK)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus), .lock(lock),
      .hw_set(hw_set), .irq(irq), .regs(regs)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [NB-1:0]    v_reset, v_wr, v_hw, v_rc;
   logic [DEPTH-1:0] v_lock;

   logic [7:0] m_reg [DEPTH];
   logic [7:0] m_rdata;
   logic       m_rvalid, m_err, m_irq;

   function automatic logic [7:0] fld(input logic [NB-1:0] v, input int i);
      return v[i*8 +: 8];
   endfunction

   function automatic logic [NB-1:0] modelImage();
      logic [NB-1:0] img;
      img = '0;
      for (int i = 0; i < DEPTH; i++) img[i*8 +: 8] = m_reg[i];
      return img;
   endfunction

   function automatic logic modelIrq();
      return |(modelImage() & v_hw);
   endfunction

   task automatic modelReset();
      for (int i = 0; i < DEPTH; i++) m_reg[i] = fld(v_reset, i);
      m_rdata  = 8'h00;
      m_rvalid = 1'b0;
      m_err    = 1'b0;
      m_irq    = modelIrq();
   endtask

   task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput(input string tag);
      checkOne({tag, ".regs"},   32'(regs),       32'(modelImage()));
      checkOne({tag, ".rdata"},  32'(bus.rdata),  32'(m_rdata));
      checkOne({tag, ".rvalid"}, 32'(bus.rvalid), 32'(m_rvalid));
      checkOne({tag, ".err"},    32'(bus.err),    32'(m_err));
      checkOne({tag, ".irq"},    32'(irq),        32'(m_irq));
   endtask

   // Drive one cycle of inputs, predict the bank's response, clock it, compare.
   task automatic applyStimulus(input string tag, input logic c, input logic w, input logic r,
                                input logic [ADDR_W-1:0] a, input logic [7:0] d,
                                input logic l, input logic [NB-1:0] h);
      logic       rd, wr, oor, lk;
      logic [7:0] nv [DEPTH];
      bus.cs = c; bus.we = w; bus.re = r; bus.addr = a; bus.wdata = d;
      lock = l; hw_set = h;
      rd  = c & r & ~w;
      wr  = c & w;
      oor = (int'(a) >= DEPTH);
      lk  = 1'b0;
      if (!oor) lk = l & v_lock[a];
      for (int i = 0; i < DEPTH; i++) begin
         nv[i] = m_reg[i];
         if (wr && !oor && !lk && int'(a) == i)
            nv[i] = (nv[i] & ~fld(v_wr, i)) | (d & fld(v_wr, i));
         if (rd && !oor && int'(a) == i)
            nv[i] = nv[i] & ~fld(v_rc, i);
         nv[i] = nv[i] | (fld(h, i) & fld(v_hw, i));
      end
      if (rd) m_rdata = oor ? 8'h00 : m_reg[a];
      m_rvalid = rd;
      m_err    = (wr && (oor || lk)) || (rd && oor);
      @(posedge clk);
      #1;
      for (int i = 0; i < DEPTH; i++) m_reg[i] = nv[i];
      m_irq = modelIrq();
      checkOutput(tag);
   endtask

   task automatic idle(input string tag);
      applyStimulus(tag, 1'b0, 1'b0, 1'b0, '0, 8'h00, lock, '0);
   endtask

   initial begin
      v_reset = P_RESET; v_wr = P_WR; v_hw = P_HW; v_rc = P_RC; v_lock = P_LOCK;
      bus.cs = 1'b0; bus.we = 1'b0; bus.re = 1'b0; bus.addr = '0; bus.wdata = '0;
      modelReset();

      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset");
      checkOne("reset.image", 32'(regs), 32'h00A500);
      checkOne("reset.irq", 32'(irq), 32'h1);
      rst = 1'b0;

      applyStimulus("wr_reg0", 1, 1, 0, 4'd0, 8'h3C, 0, '0);
      applyStimulus("rd_reg0", 1, 0, 1, 4'd0, 8'h00, 0, '0);
      checkOne("rd_reg0.lit", 32'(bus.rdata), 32'h3C);
      applyStimulus("locked_wr", 1, 1, 0, 4'd0, 8'hFF, 1, '0);
      checkOne("locked_wr.err", 32'(bus.err), 32'h1);
      applyStimulus("locked_rd", 1, 0, 1, 4'd0, 8'h00, 1, '0);
      checkOne("locked_rd.lit", 32'(bus.rdata), 32'h3C);

      applyStimulus("wr_reg1", 1, 1, 0, 4'd1, 8'h00, 0, '0);
      checkOne("wr_reg1.lit", 32'(regs[15:8]), 32'hA0);
      applyStimulus("hw_pulse", 0, 0, 0, 4'd0, 8'h00, 0, 24'h010000);
      applyStimulus("rc_read", 1, 0, 1, 4'd2, 8'h00, 0, '0);
      checkOne("rc_read.lit", 32'(bus.rdata), 32'h01);
      checkOne("rc_read.irq", 32'(irq), 32'h0);

      applyStimulus("collide", 1, 0, 1, 4'd2, 8'h00, 0, 24'h010000);
      checkOne("collide.rdata", 32'(bus.rdata), 32'h00);
      checkOne("collide.reg2", 32'(regs[23:16]), 32'h01);

      applyStimulus("wrre_both", 1, 1, 1, 4'd2, 8'h50, 0, '0);
      applyStimulus("oor_wr", 1, 1, 0, 4'd3, 8'hFF, 0, '0);
      applyStimulus("oor_rd", 1, 0, 1, 4'd3, 8'h00, 0, '0);
      checkOne("oor_rd.rdata", 32'(bus.rdata), 32'h00);

      for (int k = 0; k < 3; k++)
         applyStimulus("hw_hold", 1, 1, 0, 4'd1, 8'h00, 0, 24'h000100);
      idle("hw_release");

      applyStimulus("b2b_0", 1, 0, 1, 4'd0, 8'h00, 0, '0);
      applyStimulus("b2b_1", 1, 0, 1, 4'd1, 8'h00, 0, '0);
      applyStimulus("b2b_2", 1, 0, 1, 4'd2, 8'h00, 0, '0);
      bus.addr = 4'd0;
      rst = 1'b1;
      modelReset();
      #1;
      checkOutput("rst_async");
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_hold");
      rst = 1'b0;
      applyStimulus("post_rst", 1, 0, 1, 4'd1, 8'h00, 0, '0);
      checkOne("post_rst.lit", 32'(bus.rdata), 32'hA5);

      for (int n = 0; n < 400; n++) begin
         applyStimulus("random", 1'($urandom), 1'($urandom), 1'($urandom),
                       ADDR_W'($urandom_range(0, 4)), 8'($urandom), 1'($urandom),
                       NB'($urandom & $urandom & $urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/can_register_bank.md
# can_register_bank

Parametrised bank of `DEPTH` control/status registers of `WIDTH` bits each, with one asynchronous reset. Each bit has a mode fixed by parameter masks: CPU read/write, hardware-set sticky, clear-on-read, or constant. The bank also provides configuration locking, a registered read port and an aggregated interrupt output. It sits between the CPU bus interface and the CAN core, and is the building block for mode, command, status and interrupt register groups.

## Interface
Parameters:
- `WIDTH`, 8, bits per register.
- `DEPTH`, 4, number of registers (1..16).
- `ADDR_W`, 4, address width; requires 2^`ADDR_W` >= `DEPTH`.
- `RESET_VALUE`, 0, packed `DEPTH*WIDTH` reset image; register i occupies bits [i*WIDTH +: WIDTH].
- `WR_MASK`, all ones, packed per-bit mask; a set bit means the bit is CPU-writable.
- `HW_MASK`, 0, packed per-bit mask; a set bit means the bit is hardware-settable and sticky.
- `RC_MASK`, 0, packed per-bit mask; a set bit means the bit is cleared when its register is read.
- `LOCK_MASK`, 0, `DEPTH` bits; a set bit means the register is write-protected while `lock` is high.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `cs`  in  1  bus access strobe. One access per cycle while high.
- `we`  in  1  write qualifier.
- `re`  in  1  read qualifier.
- `addr`  in  `ADDR_W`  register index.
- `wdata`  in  `WIDTH`  write data.
- `lock`  in  1  configuration lock, high in operating mode.
- `hw_set`  in  `DEPTH*WIDTH`  one-cycle hardware event pulses.
- `rdata`  out  `WIDTH`  registered read data.
- `rvalid`  out  1  one-cycle pulse marking `rdata` valid.
- `err`  out  1  one-cycle pulse on an illegal access.
- `irq`  out  1  registered OR of all set `HW_MASK` bits.
- `regs`  out  `DEPTH*WIDTH`  live register contents, for the core.

## Operation
- Write: `cs & we` at edge k. At edge k+1, every bit with `WR_MASK`=1 takes its `wdata` value.
  - A write is ignored if `addr` >= `DEPTH`, or if `lock` = 1 and `LOCK_MASK[addr]` = 1. In both cases `err` pulses at k+1.
- Read: `cs & re & ~we` at edge k. At k+1, `rdata` holds the pre-clear value and `rvalid` = 1.
  - In the same edge, bits with `RC_MASK`=1 in that register clear.
  - If `addr` >= `DEPTH`, `rdata` = 0, `rvalid` = 1, `err` = 1, and no clear happens.
- If `cs & we & re` are all high: write only; no read and no `rvalid`.
- `hw_set` bit high with `HW_MASK`=1: the bit goes to 1 at the next edge. `hw_set` on bits without `HW_MASK` is ignored.
- Per-bit priority, highest first:
  1. `rst`
  2. `hw_set`
  3. read-clear
  4. CPU write
- Consequence of the priority: a read-clear coinciding with `hw_set` leaves the bit at 1, so no event is lost. The `rdata` returned for that read shows the old value.
- Bits with none of WR/HW/RC set are constant at their `RESET_VALUE`.
- A bit may be both HW and WR; the CPU can then clear it by writing 0, unless `hw_set` is high on the same edge.
- `lock` is sampled at the access edge only. Toggling `lock` never alters stored contents.

## Timing
- Reset values: `regs` = `RESET_VALUE`; `rdata` = 0; `rvalid`, `err` = 0; `irq` = |(`RESET_VALUE` & `HW_MASK`).
- Write-to-`regs` latency: 1 cycle. Read latency: 1 cycle, fully pipelined, back-to-back reads allowed.
- `irq` is computed from the next-state register values and registered, so it is high in the same cycle a set bit becomes visible on `regs`.
- `rst` asserted mid-access cancels the access: no `rvalid` and no `err` after release. The first access is accepted on the first edge with `rst` low.
- `hw_set` held high for N cycles is equivalent to a single pulse; the bit stays set.

## Structure
- Package `can_regbank_pkg`:
  - localparams for bit-mode encodings;
  - a function that extracts register i from a packed vector;
  - a `DEPTH` range check used by assertions.
- Sub-module `can_regbank_word`: one `WIDTH`-bit register with its mask logic and the priority mux. It is generated `DEPTH` times.
- The top level holds the address decode, the lock check, the read register and the `irq` OR.

## Test plan
- Reset check, with `RESET_VALUE`=0x..A5_00, `HW_MASK` reg1=0x01: release `rst` -> `regs` matches the image, `irq`=1, `rdata`=0, `rvalid`=0.
- Write 0x3C to reg0 with `WR_MASK`=0xFF, then read reg0 -> `rvalid` 1 cycle after `re`, `rdata`=0x3C. With `lock`=1 and `LOCK_MASK[0]`=1, writing 0xFF -> `err` pulse, reg0 stays 0x3C.
- Clear-on-read, reg2 `RC_MASK`=0x0F, bit0 HW: pulse `hw_set` bit0, read -> `rdata`=0x01, then reg2=0x00, `irq` falls.
- Collision: read reg2 on the same edge as `hw_set` bit0 -> `rdata`=0x00 (old value), reg2=0x01, `irq` stays 1.
- Out-of-range: `DEPTH`=3, `addr`=3. Write -> `err` pulse, no register changes. Read -> `rdata`=0, `rvalid`=1, `err`=1.
- Assert `rst` mid-stream of back-to-back reads -> `rvalid` and `err` held low, all registers at reset values, normal reads resume on the first cycle after release.
